// File: rtl/gray_pkg.sv
// Shared definitions for the Gray/binary codec.
// Exports the direction encodings, a generic code-word type and the
// conversion helpers used by gray_codec and gray_step_checker.
package gray_pkg;

  // Widest code word the helpers handle. Callers zero-extend narrower words
  // into this type and truncate the result back to their own width.
  localparam int unsigned GRAY_MAX_W = 64;

  // Direction select carried with each beat.
  localparam logic MODE_G2B = 1'b0;
  localparam logic MODE_B2G = 1'b1;

  typedef logic [GRAY_MAX_W-1:0] gray_word_t;

  // Gray -> binary: each binary bit is the XOR of all Gray bits at or above it.
  // The zero-extended upper bits contribute nothing, so any width <= GRAY_MAX_W
  // gives the same low-order result as a native-width conversion.
  function automatic gray_word_t gray2bin(input gray_word_t g);
    gray_word_t b;
    b = '0;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = int'(GRAY_MAX_W) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Binary -> Gray: XOR each bit with its upper neighbour.
  function automatic gray_word_t bin2gray(input gray_word_t b);
    return b ^ (b >> 1);
  endfunction

  // True when more than one bit is set. Clearing the lowest set bit leaves a
  // non-zero word only if a second bit was present.
  function automatic logic multi_bit(input gray_word_t d);
    return (d & (d - gray_word_t'(1))) != '0;
  endfunction

endpackage : gray_pkg

// File: rtl/gray_step_checker.sv
// Gray-sequence step checker with saturating error counter.
// Tracks the last accepted G2B code word and flags any accepted G2B beat that
// differs from it in more than one bit position.
//   i_clk, i_rst      clock, synchronous active-low reset
//   i_accept          a beat is accepted this cycle
//   i_mode            direction of the accepted beat
//   i_data            raw input code word of the accepted beat
//   i_clr_err         synchronous clear of the error counter
//   step_err_c        combinational: the accepted beat breaks the step rule
//   o_err_count       saturating count of step errors
module gray_step_checker
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_accept,
  input  logic                 i_mode,
  input  logic [WIDTH-1:0]     i_data,
  input  logic                 i_clr_err,
  output logic                 step_err_c,
  output logic [ERR_CNT_W-1:0] o_err_count
);

  localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] ref_word;
  logic             ref_valid;
  logic             last_mode;

  logic             mode_change;
  logic             ref_usable;
  logic [WIDTH-1:0] diff;

  // A direction change invalidates history before this beat is checked.
  assign mode_change = i_mode != last_mode;
  assign ref_usable  = ref_valid && !mode_change;
  assign diff        = i_data ^ ref_word;

  // Repeated codes (diff == 0) and single-bit steps are legal.
  always_comb begin
    step_err_c = 1'b0;
    if (i_accept && (i_mode == MODE_G2B) && ref_usable) begin
      step_err_c = multi_bit(gray_word_t'(diff));
    end
  end

  // History update: G2B beats become the new reference, B2G beats drop it.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      ref_word  <= '0;
      ref_valid <= 1'b0;
      last_mode <= MODE_G2B;
    end else if (i_accept) begin
      last_mode <= i_mode;
      if (i_mode == MODE_G2B) begin
        ref_word  <= i_data;
        ref_valid <= 1'b1;
      end else begin
        ref_valid <= 1'b0;
      end
    end
  end

  // Saturating counter; a clear coinciding with an error restarts at one so
  // the new event is kept.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      o_err_count <= '0;
    end else if (i_clr_err) begin
      o_err_count <= step_err_c ? ERR_CNT_W'(1) : '0;
    end else if (step_err_c && (o_err_count != CNT_MAX)) begin
      o_err_count <= o_err_count + ERR_CNT_W'(1);
    end
  end

endmodule : gray_step_checker

// File: rtl/gray_codec.sv
// Registered, bidirectional Gray/binary converter with valid/ready handshake.
// Each accepted beat is converted in the direction given by i_mode and held in
// an output register until the downstream consumer takes it.
//   i_clk, i_rst      clock, synchronous active-low reset
//   i_mode            0 = Gray->binary, 1 = binary->Gray, per beat
//   i_valid/o_ready   input handshake; o_ready is combinational
//   i_data            input code word
//   o_valid/i_ready   output handshake
//   o_data            converted word
//   o_step_err        the beat in o_data violated the Gray single-step rule
//   o_err_count       saturating step-error count
//   i_clr_err         synchronous clear of o_err_count
module gray_codec
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_mode,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [WIDTH-1:0]     i_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [WIDTH-1:0]     o_data,
  output logic                 o_step_err,
  output logic [ERR_CNT_W-1:0] o_err_count,
  input  logic                 i_clr_err
);

  logic             accept;
  logic [WIDTH-1:0] conv_data;
  logic             step_err_c;

  // The output register can take a new beat when empty or draining this cycle.
  assign o_ready = !o_valid || i_ready;
  assign accept  = i_valid && o_ready;

  // Direction mux; WIDTH must not exceed GRAY_MAX_W.
  always_comb begin
    conv_data = '0;
    if (i_mode == MODE_B2G) begin
      conv_data = WIDTH'(bin2gray(gray_word_t'(i_data)));
    end else begin
      conv_data = WIDTH'(gray2bin(gray_word_t'(i_data)));
    end
  end

  gray_step_checker #(
    .WIDTH     (WIDTH),
    .ERR_CNT_W (ERR_CNT_W)
  ) u_checker (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_accept    (accept),
    .i_mode      (i_mode),
    .i_data      (i_data),
    .i_clr_err   (i_clr_err),
    .step_err_c  (step_err_c),
    .o_err_count (o_err_count)
  );

  // Output register: load on accept, empty on drain, otherwise hold.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      o_valid    <= 1'b0;
      o_data     <= '0;
      o_step_err <= 1'b0;
    end else if (accept) begin
      o_valid    <= 1'b1;
      o_data     <= conv_data;
      o_step_err <= step_err_c;
    end else if (i_ready) begin
      o_valid    <= 1'b0;
    end
  end

endmodule : gray_codec
